// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 miss-fill controller.
package cache_pkg;

    // Fill controller states
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Block geometry: 16-byte blocks of eight 16-bit words, 64 sets
    localparam int WORDS_PER_BLOCK = 8;
    localparam int INDEX_W         = 6;
    localparam int OFFSET_W        = 4;

    // Set index lives directly above the block offset
    localparam int IDX_LSB = 4;
    localparam int IDX_MSB = 9;

    // Request/response counters are wide enough to hold WORDS_PER_BLOCK itself
    localparam int CNT_W      = 4;
    localparam int WORD_SEL_W = 3;

endpackage

// File: rtl/fill_counter.sv
// Small up-counter with synchronous clear, enable and terminal-count flag.
module fill_counter #(
    parameter int             W      = 4,
    parameter logic [W-1:0]   TC_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over enable
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/cache_fill_fsm.sv
// L1 miss-fill controller: issues eight word reads for the missing block,
// writes each returned word into the data array and the tag on the last one.
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int INDEX_W         = cache_pkg::INDEX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_detected,
    input  logic [ADDR_W-1:0]    miss_address,
    input  logic                 memory_data_valid,
    output logic                 fsm_busy,
    output logic                 memory_read,
    output logic [ADDR_W-1:0]    memory_address,
    output logic [INDEX_W-1:0]   block_index,
    output logic [2:0]           word_sel,
    output logic                 write_data_array,
    output logic                 write_tag_array
);

    localparam int CNT_W    = cache_pkg::CNT_W;
    localparam int OFFSET_W = cache_pkg::OFFSET_W;

    // Request counter stops once every word has been asked for;
    // response counter flags the final word of the block.
    localparam logic [CNT_W-1:0] REQ_TC  = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] RECV_TC = CNT_W'(WORDS_PER_BLOCK - 1);

    cache_pkg::fill_state_e state_q, state_d;

    logic [ADDR_W-1:0]  base_q;
    logic [INDEX_W-1:0] index_q;

    logic               accept;
    logic               req_en;
    logic               recv_en;
    logic [CNT_W-1:0]   req_cnt;
    logic [CNT_W-1:0]   recv_cnt;
    logic               req_done;
    logic               recv_last;

    // Offset bits are dropped on purpose (block-aligned base), and recv_cnt
    // never needs its top bit to select a word.
    logic unused_bits;
    assign unused_bits = ^{miss_address[OFFSET_W-1:0], recv_cnt[CNT_W-1]};

    fill_counter #(
        .W      (CNT_W),
        .TC_VAL (REQ_TC)
    ) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (req_en),
        .cnt_o (req_cnt),
        .tc_o  (req_done)
    );

    fill_counter #(
        .W      (CNT_W),
        .TC_VAL (RECV_TC)
    ) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (recv_en),
        .cnt_o (recv_cnt),
        .tc_o  (recv_last)
    );

    // Next state and all datapath strobes; everything idles at 0
    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        req_en           = 1'b0;
        recv_en          = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_sel         = '0;
        unique case (state_q)
            cache_pkg::IDLE: begin
                // Returned data is ignored here; only a miss starts work
                if (miss_detected) begin
                    accept  = 1'b1;
                    state_d = cache_pkg::FILL;
                end
            end
            cache_pkg::FILL: begin
                // Request side runs back-to-back until all words are asked for
                if (!req_done) begin
                    memory_read    = 1'b1;
                    memory_address = base_q + ADDR_W'({req_cnt, 1'b0});
                    req_en         = 1'b1;
                end
                // Response side is counted, so any memory latency works
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_sel         = recv_cnt[2:0];
                    recv_en          = 1'b1;
                    if (recv_last) begin
                        write_tag_array = 1'b1;
                        state_d         = cache_pkg::IDLE;
                    end
                end
            end
            default: state_d = cache_pkg::IDLE;
        endcase
    end

    // State, block base and set index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= cache_pkg::IDLE;
            base_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_q  <= {miss_address[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                index_q <= miss_address[cache_pkg::IDX_MSB:cache_pkg::IDX_LSB];
            end
        end
    end

    assign fsm_busy    = (state_q == cache_pkg::FILL);
    assign block_index = index_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: stimulus pushes expected requests and
// writes, a negedge monitor pops and compares, a small memory model answers.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic [5:0]  block_index;
    logic [2:0]  word_sel;
    logic        write_data_array;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .block_index       (block_index),
        .word_sel          (word_sel),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array)
    );

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } req_t;

    typedef struct {
        logic [2:0] ws;
        logic       tag;
        logic [5:0] idx;
        int         cyc;   // -1 means any cycle
    } wr_t;

    req_t req_q[$];
    wr_t  wr_q[$];
    int   pend_q[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int lat = 4;
    bit gap_en = 1'b0;
    bit idle_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: fixed latency, optional random gaps, in-order returns
    always @(negedge clk) begin
        if (rst) pend_q.delete();
        else if (memory_read) pend_q.push_back(cyc + lat);
    end

    always @(posedge clk) begin
        #1;
        memory_data_valid = idle_pulse;
        if (pend_q.size() > 0 && pend_q[0] <= cyc &&
            !(gap_en && $urandom_range(0, 2) == 0)) begin
            void'(pend_q.pop_front());
            memory_data_valid = 1'b1;
        end
    end

    // Monitor: compare every request and write against the scoreboard
    always @(negedge clk) begin : monitor
        req_t r;
        wr_t  w;
        if (memory_read) begin
            if (req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_req: got read of 0x%0h expected none (cyc %0d)", memory_address, cyc);
            end else begin
                r = req_q.pop_front();
                chk("req_addr", memory_address, r.addr);
                if (r.cyc >= 0) chk("req_cycle", cyc, r.cyc);
            end
        end
        if (write_data_array) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_write: got word_sel %0d expected none (cyc %0d)", word_sel, cyc);
            end else begin
                w = wr_q.pop_front();
                chk("word_sel", word_sel, w.ws);
                chk("tag_write", write_tag_array, w.tag);
                chk("wr_index", block_index, w.idx);
                if (w.cyc >= 0) chk("wr_cycle", cyc, w.cyc);
            end
        end
        if (write_tag_array && !write_data_array) begin
            checks++; errors++;
            $display("FAIL lone_tag: got tag write without data write expected none (cyc %0d)", cyc);
        end
        if (!fsm_busy)
            chk("idle_outs", {memory_read, write_data_array, write_tag_array, word_sel, memory_address}, 0);
    end

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cyc == target) return;
        end
        checks++; errors++;
        $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, target);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!fsm_busy) return;
        end
        checks++; errors++;
        $display("FAIL busy_timeout: got busy after %0d cycles expected idle", budget);
    endtask

    // Present a miss; t0 is the cyc value of the cycle in which it is sampled
    task automatic issue_miss(input logic [15:0] a, input bit hold, output int t0);
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = a;
        @(posedge clk); #1;
        if (!hold) miss_detected = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic push_fill(input logic [15:0] base, input logic [5:0] idx, input int t0,
                             input bit timed_wr, input int nreq, input int nwr);
        for (int i = 0; i < nreq; i++)
            req_q.push_back('{base + 16'(2 * i), t0 + 1 + i});
        for (int i = 0; i < nwr; i++)
            wr_q.push_back('{3'(i), (i == 7), idx, timed_wr ? t0 + 5 + i : -1});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0;

        // Reset and idle with stray memory returns
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", fsm_busy, 0);
        chk("rst_index", block_index, 0);
        chk("rst_req_cnt", dut.u_req_cnt.cnt_q, 0);
        chk("rst_recv_cnt", dut.u_recv_cnt.cnt_q, 0);
        for (int i = 0; i < 5; i++) begin
            idle_pulse = (i % 2 == 0);
            @(negedge clk);
            chk("idle_wr", write_data_array, 0);
            chk("idle_busy", fsm_busy, 0);
        end
        idle_pulse = 1'b0;
        @(negedge clk);

        // Miss at 0x1236, 4-cycle memory, exact timing
        issue_miss(16'h1236, 1'b0, t0);
        push_fill(16'h1230, 6'h23, t0, 1'b1, 8, 8);
        wait_cyc(t0 + 12);
        chk("busy_c12", fsm_busy, 1);
        wait_cyc(t0 + 13);
        chk("busy_c13", fsm_busy, 0);
        chk("index_hold", block_index, 6'h23);

        // Gapped responses
        gap_en = 1'b1;
        issue_miss(16'h4A58, 1'b0, t0);
        push_fill(16'h4A50, 6'h25, t0, 1'b0, 8, 8);
        wait_idle(400);
        gap_en = 1'b0;
        chk("gap_index", block_index, 6'h25);

        // Miss held high: second fill starts in the single idle cycle
        issue_miss(16'h2345, 1'b1, t0);
        miss_address = 16'h5678;
        push_fill(16'h2340, 6'h34, t0, 1'b1, 8, 8);
        push_fill(16'h5670, 6'h27, t0 + 13, 1'b1, 8, 8);
        wait_cyc(t0 + 13);
        chk("held_gap_busy", fsm_busy, 0);
        @(posedge clk); #1;
        miss_detected = 1'b0;
        wait_cyc(t0 + 14);
        chk("held_restart_busy", fsm_busy, 1);
        chk("held_new_index", block_index, 6'h27);
        wait_idle(100);

        // Reset in the cycle of the third response
        issue_miss(16'h0810, 1'b0, t0);
        push_fill(16'h0810, 6'h01, t0, 1'b1, 7, 3);
        wait_cyc(t0 + 6);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cyc(t0 + 8);
        chk("mid_rst_busy", fsm_busy, 0);
        chk("mid_rst_index", block_index, 0);
        chk("mid_rst_req_cnt", dut.u_req_cnt.cnt_q, 0);
        chk("mid_rst_recv_cnt", dut.u_recv_cnt.cnt_q, 0);
        repeat (3) @(negedge clk);
        issue_miss(16'h0810, 1'b0, t0);
        push_fill(16'h0810, 6'h01, t0, 1'b1, 8, 8);
        wait_idle(100);

        // Top of the address space: no carry past the block
        issue_miss(16'hFFF0, 1'b0, t0);
        push_fill(16'hFFF0, 6'h3F, t0, 1'b1, 8, 8);
        wait_cyc(t0 + 13);
        chk("top_busy", fsm_busy, 0);
        chk("top_index", block_index, 6'h3F);

        repeat (5) @(negedge clk);
        chk("req_q_empty", req_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
